// File: rtl/fm_tx_pkg.sv
// fm_tx_pkg: shared constants and FSM state type for the FM transmitter audio path.
// Audio samples are AUDIO_W bits wide and offset binary, so AUDIO_MID encodes silence.
package fm_tx_pkg;

   localparam int AUDIO_W   = 10;
   localparam int AUDIO_MID = 512;
   localparam int EMPH_FRAC = 4;

   typedef enum logic [1:0] {
      ACCUM,
      CALC_L,
      CALC_R,
      OUT
   } emph_state_t;

endpackage

// File: rtl/preemph_mac.sv
// preemph_mac: y = sat(x + ((x - x_prev) * k) >>> EMPH_FRAC), purely combinational.
// Ports: x, x_prev signed samples; k unsigned Q4.4 gain; y saturated signed result.
module preemph_mac
   import fm_tx_pkg::*;
(
   input  logic signed [AUDIO_W-1:0] x,
   input  logic signed [AUDIO_W-1:0] x_prev,
   input  logic        [7:0]         k,
   output logic signed [AUDIO_W-1:0] y
);

   localparam int PW = 2 * AUDIO_W;
   localparam int QW = PW - EMPH_FRAC;
   localparam int SW = QW + 1;

   logic signed [AUDIO_W:0] d;
   logic signed [PW-1:0]    d_ext;
   logic signed [PW-1:0]    k_ext;
   logic signed [PW-1:0]    prod;
   logic signed [QW-1:0]    p;
   logic signed [SW-1:0]    s;
   logic                    unused_frac;

   assign d = {x[AUDIO_W-1], x} - {x_prev[AUDIO_W-1], x_prev};

   assign d_ext = {{(PW-AUDIO_W-1){d[AUDIO_W]}}, d};
   assign k_ext = {{(PW-8){1'b0}}, k};
   assign prod  = d_ext * k_ext;

   // Dropping the fraction bits of a two's complement value is a floor shift.
   assign p           = prod[PW-1:EMPH_FRAC];
   assign unused_frac = ^prod[EMPH_FRAC-1:0];

   assign s = {{(SW-AUDIO_W){x[AUDIO_W-1]}}, x} + {p[QW-1], p};

   always_comb begin
      y = s[AUDIO_W-1:0];
      if (s > SW'(AUDIO_MID - 1)) begin
         y = AUDIO_W'(AUDIO_MID - 1);
      end else if (s < -SW'(AUDIO_MID)) begin
         y = AUDIO_W'(-AUDIO_MID);
      end
   end

endmodule

// File: rtl/audio_preemph.sv
// audio_preemph: decimating stereo averager with optional pre-emphasis (AUDIO_PREEMPH_EN).
// Ports: i_clk, i_rst_n, i_audio_l/r in, i_emph_gain Q4.4; o_audio_l/r, o_valid strobe.
module audio_preemph
   import fm_tx_pkg::*;
#(
   parameter int DECIM_LOG2 = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [AUDIO_W-1:0] i_audio_l,
   input  logic [AUDIO_W-1:0] i_audio_r,
   input  logic [7:0]         i_emph_gain,
   output logic [AUDIO_W-1:0] o_audio_l,
   output logic [AUDIO_W-1:0] o_audio_r,
   output logic               o_valid
);

   localparam int SUM_W = AUDIO_W + DECIM_LOG2;

   logic [DECIM_LOG2-1:0]     cnt;
   logic [SUM_W-1:0]          sum_l;
   logic [SUM_W-1:0]          sum_r;
   logic                      wrap;
   logic signed [AUDIO_W-1:0] avg_l;
   logic signed [AUDIO_W-1:0] avg_r;
   logic signed [AUDIO_W-1:0] x_l;
   logic signed [AUDIO_W-1:0] x_r;
   logic signed [AUDIO_W-1:0] xp_l;
   logic signed [AUDIO_W-1:0] xp_r;
   logic signed [AUDIO_W-1:0] y_l;
   logic signed [AUDIO_W-1:0] y_r;
   logic signed [AUDIO_W-1:0] mac_x;
   logic signed [AUDIO_W-1:0] mac_y;
   logic [7:0]                k;
   emph_state_t               state;

   assign wrap = &cnt;

   // Average, with MSB flipped to turn offset binary into two's complement.
   assign avg_l = {~sum_l[SUM_W-1], sum_l[SUM_W-2:DECIM_LOG2]};
   assign avg_r = {~sum_r[SUM_W-1], sum_r[SUM_W-2:DECIM_LOG2]};

   // The wrap-cycle sample seeds the next frame so no input is dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt   <= '0;
         sum_l <= '0;
         sum_r <= '0;
      end else begin
         cnt <= cnt + DECIM_LOG2'(1);
         if (wrap) begin
            sum_l <= SUM_W'(i_audio_l);
            sum_r <= SUM_W'(i_audio_r);
         end else begin
            sum_l <= sum_l + SUM_W'(i_audio_l);
            sum_r <= sum_r + SUM_W'(i_audio_r);
         end
      end
   end

   // One multiplier, time-shared: left in CALC_L, right in CALC_R.
   assign mac_x = (state == CALC_R) ? x_r : x_l;

`ifdef AUDIO_PREEMPH_EN
   logic signed [AUDIO_W-1:0] mac_xp;

   assign mac_xp = (state == CALC_R) ? xp_r : xp_l;

   preemph_mac u_mac (
      .x      (mac_x),
      .x_prev (mac_xp),
      .k      (k),
      .y      (mac_y)
   );
`else
   logic unused_emph;

   assign unused_emph = ^{k, xp_l, xp_r};
   assign mac_y       = mac_x;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ACCUM;
         x_l       <= '0;
         x_r       <= '0;
         xp_l      <= '0;
         xp_r      <= '0;
         y_l       <= '0;
         y_r       <= '0;
         k         <= '0;
         o_audio_l <= AUDIO_W'(AUDIO_MID);
         o_audio_r <= AUDIO_W'(AUDIO_MID);
         o_valid   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         unique case (state)
            ACCUM: begin
               if (wrap) begin
                  x_l   <= avg_l;
                  x_r   <= avg_r;
                  k     <= i_emph_gain;
                  state <= CALC_L;
               end
            end
            CALC_L: begin
               y_l   <= mac_y;
               xp_l  <= x_l;
               state <= CALC_R;
            end
            CALC_R: begin
               y_r   <= mac_y;
               xp_r  <= x_r;
               state <= OUT;
            end
            OUT: begin
               o_audio_l <= {~y_l[AUDIO_W-1], y_l[AUDIO_W-2:0]};
               o_audio_r <= {~y_r[AUDIO_W-1], y_r[AUDIO_W-2:0]};
               o_valid   <= 1'b1;
               state     <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_preemph.sv
// tb_audio_preemph: random and directed stimulus, frame-level reference model,
// expected strobes queued by the driver and popped by an independent monitor.
module tb_audio_preemph;

   localparam int D = 8;
   localparam int N = 1 << D;

   typedef struct {
      int l;
      int r;
      int due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] audio_l = 10'd512;
   logic [9:0] audio_r = 10'd512;
   logic [7:0] gain = 8'd0;
   logic [9:0] out_l;
   logic [9:0] out_r;
   logic       valid;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   edges = 0;
   int   acc_l = 0;
   int   acc_r = 0;
   int   xp_l = 0;
   int   xp_r = 0;
   int   hold_l = 512;
   int   hold_r = 512;

   always #10 clk = ~clk;

   audio_preemph #(.DECIM_LOG2(D)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_audio_l   (audio_l),
      .i_audio_r   (audio_r),
      .i_emph_gain (gain),
      .o_audio_l   (out_l),
      .o_audio_r   (out_r),
      .o_valid     (valid)
   );

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (edge %0d)",
                  name, act, want, edges);
      end
   endtask

   // Signed-domain emphasis with floor rounding and clamping.
   function automatic int emph(input int x, input int xp, input int k);
      int kk;
      int prod;
      int p;
      int y;
`ifdef AUDIO_PREEMPH_EN
      kk = k;
`else
      kk = 0 * k;
`endif
      prod = (x - xp) * kk;
      if (prod >= 0) p = prod / 16;
      else p = -((-prod + 15) / 16);
      y = x + p;
      if (y > 511) y = 511;
      if (y < -512) y = -512;
      return y;
   endfunction

   // Drive one sample pair; it is captured at the next rising edge.
   task automatic step(input int l, input int r, input int k);
      exp_t ent;
      int   xl;
      int   xr;
      audio_l = 10'(l);
      audio_r = 10'(r);
      gain    = 8'(k);
      @(posedge clk);
      edges++;
      if (edges % N == 0) begin
         xl = acc_l / N - 512;
         xr = acc_r / N - 512;
         ent.l   = emph(xl, xp_l, k) + 512;
         ent.r   = emph(xr, xp_r, k) + 512;
         ent.due = edges + 3;
         q.push_back(ent);
         xp_l  = xl;
         xp_r  = xr;
         acc_l = l;
         acc_r = r;
      end else begin
         acc_l += l;
         acc_r += r;
      end
      #5;
   endtask

   task automatic run(input int n, input int l, input int r, input int k);
      for (int i = 0; i < n; i++) step(l, r, k);
   endtask

   task automatic apply_reset(input int low_cycles);
      rst_n = 1'b0;
      #1;
      check("rst_out_l", int'(out_l), 512);
      check("rst_out_r", int'(out_r), 512);
      check("rst_valid", int'(valid), 0);
      q.delete();
      edges  = 0;
      acc_l  = 0;
      acc_r  = 0;
      xp_l   = 0;
      xp_r   = 0;
      hold_l = 512;
      hold_r = 512;
      repeat (low_cycles) @(posedge clk);
      #5;
      rst_n = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (valid) begin
               if (q.size() == 0) begin
                  check("spurious_valid", int'(valid), 0);
               end else begin
                  mon_e = q.pop_front();
                  check("strobe_edge", edges, mon_e.due);
                  check("out_l", int'(out_l), mon_e.l);
                  check("out_r", int'(out_r), mon_e.r);
                  hold_l = mon_e.l;
                  hold_r = mon_e.r;
               end
            end else begin
               check("hold_l", int'(out_l), hold_l);
               check("hold_r", int'(out_r), hold_r);
               if (q.size() > 0 && edges > q[0].due) begin
                  check("strobe_late", edges, q[0].due);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #5;
      apply_reset(3);

      run(N - 1, 512, 512, 'h9C);
      run(3 * N, 512, 512, 'h9C);

      run(2 * N, 512, 512, 'h10);
      run(2 * N, 612, 612, 'h10);

      run(2 * N, 0, 0, 'h9C);
      run(2 * N, 1023, 1023, 'h9C);
      run(2 * N, 0, 0, 'h9C);

      run(3 * N, 700, 300, 'h00);

      for (int f = 0; f < 6; f++) begin
         int kf;
         int kn;
         int sw;
         kf = int'($urandom_range(255));
         kn = int'($urandom_range(255));
         sw = int'($urandom_range(N - 1));
         for (int i = 0; i < N; i++) begin
            step(int'($urandom_range(1023)), int'($urandom_range(1023)),
                 (i < sw) ? kf : kn);
         end
      end

      run(2 * N, 700, 300, 'h00);
      run(100, 700, 300, 'h00);
      apply_reset(2);

      run(N - 1, 700, 300, 'h10);
      run(4, 700, 300, 'h10);
      apply_reset(1);

      run(N - 1, 300, 800, 'h9C);
      run(2 * N, 300, 800, 'h9C);
      run(2 * N, 1023, 0, 'h9C);

      for (int i = 0; i < 2 * N && q.size() > 0; i++) step(512, 512, 0);
      check("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_preemph.md
AUDIO_PREEMPH -- requirements
Module: audio_preemph

Interface
REQ-001 Parameter DECIM_LOG2, default 8, decimation ratio 2^DECIM_LOG2 (frame length in i_clk cycles).
REQ-002 i_clk  input  1  50 MHz system clock; the only clock.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_audio_l  input  10  left ADC sample, offset binary (512 = silence), new value every cycle.
REQ-005 i_audio_r  input  10  right ADC sample, offset binary.
REQ-006 i_emph_gain  input  8  pre-emphasis gain K, unsigned Q4.4 (0x10 = 1.0, 0x9C = 9.75 ≈ 50 us at 195.3 kHz).
REQ-007 o_audio_l  output  10  emphasised left sample, offset binary, to FM mixer.
REQ-008 o_audio_r  output  10  emphasised right sample, offset binary.
REQ-009 o_valid  output  1  one-cycle strobe; o_audio_l/o_audio_r updated in the same cycle.

Function
REQ-010 Each channel SHALL accumulate 2^DECIM_LOG2 consecutive samples into a (10+DECIM_LOG2)-bit unsigned sum; frame counter wraps 2^DECIM_LOG2-1 -> 0.
REQ-011 At wrap, average = sum >> DECIM_LOG2, converted to signed x by inverting the MSB; accumulator restarts with the wrap-cycle sample (no sample lost).
REQ-012 i_emph_gain SHALL be latched once per frame at wrap; mid-frame changes take effect next frame.
REQ-013 Per channel: d = x - x_prev (11-bit signed); p = (d * K) >>> 4 (arithmetic); y = x + p; y saturated to [-512, +511]; x_prev <= x.
REQ-014 FSM states ACCUM, CALC_L, CALC_R, OUT: ACCUM -> CALC_L at wrap; CALC_L -> CALC_R -> OUT unconditionally; OUT -> ACCUM; one shared multiplier used in CALC_L then CALC_R.
REQ-015 Accumulation SHALL continue every cycle regardless of FSM state.
REQ-016 In OUT, o_audio_l/o_audio_r <= y with MSB inverted and o_valid = 1; o_valid is exactly 3 cycles after the wrap cycle.
REQ-017 Outputs SHALL hold between strobes; o_valid period = 2^DECIM_LOG2 cycles.
REQ-018 DECIM_LOG2 SHALL be >= 2 so the FSM completes within one frame.
REQ-019 K = 0 SHALL yield y = x exactly.

Reset
REQ-020 On i_rst_n low, immediately: o_audio_l = o_audio_r = 10'd512, o_valid = 0, accumulators = 0, frame counter = 0, x_prev = 0, latched K = 0, FSM = ACCUM.
REQ-021 Reset mid-frame or mid-FSM SHALL discard the partial frame; first o_valid after release occurs 2^DECIM_LOG2 + 3 cycles after the first active edge.

Configuration
REQ-022 Macro AUDIO_PREEMPH_EN defined: REQ-013 arithmetic active.
REQ-023 Macro AUDIO_PREEMPH_EN undefined: y = x (decimated average only), no multiplier instantiated, i_emph_gain ignored; timing and reset unchanged.

Structure
REQ-024 Shared package fm_tx_pkg SHALL hold AUDIO_W = 10, AUDIO_MID = 512, EMPH_FRAC = 4 and the FSM state enum.
REQ-025 Saturating multiply-add SHALL be sub-module preemph_mac (x, x_prev, K -> y), combinational, instantiated once.

Verification
REQ-026 Both inputs held 512, K = 0x9C -> every o_valid carries 512/512; strobes every 256 cycles.
REQ-027 Inputs 512 then 612 aligned to frame boundary, K = 0x10 -> next two outputs 712 then 612.
REQ-028 Inputs 0 then 1023 at frame boundary, K = 0x9C -> output 1023 (positive saturation); reverse step -> 0.
REQ-029 L = 700, R = 300 constant, K = 0x00 -> outputs 700/300, no cross-channel leakage.
REQ-030 Assert i_rst_n low 100 cycles into a frame -> outputs 512 and o_valid 0 immediately; first strobe 259 cycles after release.
REQ-031 AUDIO_PREEMPH_EN undefined, REQ-027 stimulus -> outputs 612, 612.
